// File: rtl/spi_reg_responder_if.sv
// spi_reg_responder_if: SPI pins plus register-bus side of the SPI register responder.
interface spi_reg_responder_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 7
);
    logic              CS_L;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic              MISO_OE;
    logic [ADDR_W-1:0] reg_addr;
    logic [WIDTH-1:0]  reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [WIDTH-1:0]  reg_rdata;
    logic              busy;
    logic              frame_done;

    modport slave (
        input  CS_L, SCLK, MOSI, reg_rdata,
        output MISO, MISO_OE, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done
    );

    modport master (
        output CS_L, SCLK, MOSI, reg_rdata,
        input  MISO, MISO_OE, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done
    );
endinterface

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 responder turning command/burst frames into register-bus strobes.
module spi_reg_responder #(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    spi_reg_responder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {WAIT_CSH, IDLE, CMD, WDATA, RDATA} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] cs_s, sclk_s, mosi_s;
    logic cs_q, sclk_q, load;
    logic [CW-1:0] bit_cnt;
    logic [WIDTH-2:0] rx_sh;
    logic [WIDTH-1:0] tx_sh, rx_next;
    logic [ADDR_W-1:0] addr, addr_inc;
    logic cs, rise, fall, active, start, end_frame, byte_done;

    always_comb begin
        cs        = cs_s[SYNC_STAGES-1];
        rise      = sclk_s[SYNC_STAGES-1] & ~sclk_q;
        fall      = ~sclk_s[SYNC_STAGES-1] & sclk_q;
        rx_next   = {rx_sh, mosi_s[SYNC_STAGES-1]};
        addr_inc  = addr + ADDR_W'(1);
        active    = state inside {CMD, WDATA, RDATA};
        start     = state == IDLE && cs_q && !cs;
        end_frame = active && cs;
        byte_done = active && !cs && rise && bit_cnt == CW'(WIDTH - 1);
        state_n   = state == WAIT_CSH ? (cs ? IDLE : WAIT_CSH)
                  : start ? CMD
                  : end_frame ? IDLE
                  : byte_done && state == CMD ? (rx_next[WIDTH-1] ? RDATA : WDATA)
                  : state;
    end

    assign bus.busy = active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= WAIT_CSH;
            cs_s           <= '0;
            sclk_s         <= '0;
            mosi_s         <= '0;
            cs_q           <= 1'b0;
            sclk_q         <= 1'b0;
            load           <= 1'b0;
            bit_cnt        <= '0;
            rx_sh          <= '0;
            tx_sh          <= '0;
            addr           <= '0;
            bus.MISO       <= 1'b0;
            bus.MISO_OE    <= 1'b0;
            bus.reg_addr   <= '0;
            bus.reg_wdata  <= '0;
            bus.reg_we     <= 1'b0;
            bus.reg_re     <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            cs_s           <= {cs_s[SYNC_STAGES-2:0], bus.CS_L};
            sclk_s         <= {sclk_s[SYNC_STAGES-2:0], bus.SCLK};
            mosi_s         <= {mosi_s[SYNC_STAGES-2:0], bus.MOSI};
            cs_q           <= cs;
            sclk_q         <= sclk_s[SYNC_STAGES-1];
            state          <= state_n;
            bus.reg_we     <= 1'b0;
            bus.reg_re     <= 1'b0;
            bus.frame_done <= 1'b0;
            load           <= 1'b0;
            if (start) begin
                bit_cnt     <= '0;
                bus.MISO    <= 1'b0;
                bus.MISO_OE <= 1'b1;
            end
            if (end_frame) begin
                bus.MISO       <= 1'b0;
                bus.MISO_OE    <= 1'b0;
                bus.frame_done <= 1'b1;
            end
            if (active && !cs && rise) begin
                rx_sh   <= rx_next[WIDTH-2:0];
                bit_cnt <= byte_done ? '0 : bit_cnt + CW'(1);
            end
            if (active && !cs && fall && state == RDATA) begin
                bus.MISO <= tx_sh[WIDTH-1];
                tx_sh    <= tx_sh << 1;
            end
            // read data arrives one clk after reg_re and lands long before the next SCLK fall
            if (load)
                tx_sh <= bus.reg_rdata;
            if (byte_done) begin
                if (state == CMD) begin
                    addr         <= rx_next[ADDR_W-1:0];
                    bus.reg_addr <= rx_next[ADDR_W-1:0];
                    bus.reg_re   <= rx_next[WIDTH-1];
                    load         <= rx_next[WIDTH-1];
                end else if (state == WDATA) begin
                    bus.reg_we    <= 1'b1;
                    bus.reg_addr  <= addr;
                    bus.reg_wdata <= rx_next;
                    addr          <= addr_inc;
                end else begin
                    addr         <= addr_inc;
                    bus.reg_addr <= addr_inc;
                    bus.reg_re   <= 1'b1;
                    load         <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: directed and random SPI frames checked against a frame-level register model.
module tb_spi_reg_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    spi_reg_responder_if #(.WIDTH(8), .ADDR_W(7)) bus ();

    spi_reg_responder #(.WIDTH(8), .ADDR_W(7), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [128];
    logic [14:0] we_q [$];
    logic [6:0]  re_q [$];
    int done_cnt = 0, both_err = 0, wide_err = 0, miso_hi = 0;
    logic prev_we = 1'b0, prev_re = 1'b0;

    // register file read port and bus observer
    always @(negedge clk) begin
        if (bus.reg_re) begin
            bus.reg_rdata = mem[bus.reg_addr];
            re_q.push_back(bus.reg_addr);
        end
        if (bus.reg_we) we_q.push_back({bus.reg_addr, bus.reg_wdata});
        if (bus.reg_we && bus.reg_re) both_err++;
        if ((bus.reg_we && prev_we) || (bus.reg_re && prev_re)) wide_err++;
        prev_we = bus.reg_we;
        prev_re = bus.reg_re;
        if (bus.frame_done) done_cnt++;
        if (bus.MISO) miso_hi++;
    end

    string cur = "reset";
    logic [7:0] fb [8];
    logic [7:0] rxb [8];
    int nb, nx;
    int we0, re0, done0, miso0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur, name, obs, exp);
        end
    endtask

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic m);
        bus.MOSI = b;
        half();
        m = bus.MISO;
        bus.SCLK = 1'b1;
        half();
        bus.SCLK = 1'b0;
    endtask

    task automatic mark();
        we0 = we_q.size();
        re0 = re_q.size();
        done0 = done_cnt;
        miso0 = miso_hi;
    endtask

    task automatic chk_zero();
        chk("miso", bus.MISO, 0);
        chk("oe", bus.MISO_OE, 0);
        chk("we", bus.reg_we, 0);
        chk("re", bus.reg_re, 0);
        chk("busy", bus.busy, 0);
        chk("done", bus.frame_done, 0);
        chk("addr", bus.reg_addr, 0);
        chk("wdata", bus.reg_wdata, 0);
    endtask

    task automatic run_frame();
        logic m;
        mark();
        bus.CS_L = 1'b0;
        half();
        for (int i = 0; i < nb; i++)
            for (int j = 7; j >= 0; j--) begin
                send_bit(fb[i][j], m);
                rxb[i][j] = m;
            end
        for (int j = 0; j < nx; j++) send_bit(1'($urandom), m);
        half();
        bus.CS_L = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // expectations derived from the frame bytes and the register contents before the frame
    task automatic check_frame();
        logic [6:0] a;
        a = fb[0][6:0];
        chk("frame_done", done_cnt - done0, 1);
        chk("busy_end", bus.busy, 0);
        chk("oe_end", bus.MISO_OE, 0);
        chk("miso_end", bus.MISO, 0);
        chk("we_re_overlap", both_err, 0);
        chk("strobe_width", wide_err, 0);
        if (fb[0][7]) begin
            chk("we_cnt", we_q.size() - we0, 0);
            chk("re_cnt", re_q.size() - re0, nb);
            for (int i = 0; i < nb; i++)
                if (re0 + i < re_q.size()) chk("re_addr", re_q[re0 + i], 7'(a + i));
            chk("rx0", rxb[0], 0);
            for (int i = 1; i < nb; i++) chk("rx", rxb[i], mem[7'(a + i - 1)]);
        end else begin
            chk("re_cnt", re_q.size() - re0, 0);
            chk("we_cnt", we_q.size() - we0, nb - 1);
            chk("miso_zero", miso_hi - miso0, 0);
            for (int i = 1; i < nb; i++) begin
                if (we0 + i - 1 < we_q.size()) begin
                    chk("we_addr", we_q[we0 + i - 1][14:8], 7'(a + i - 1));
                    chk("we_data", we_q[we0 + i - 1][7:0], fb[i]);
                end
                mem[7'(a + i - 1)] = fb[i];
            end
        end
    endtask

    initial begin
        logic m;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        bus.CS_L = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero();
        rst = 1'b1;
        repeat (10) @(negedge clk);

        cur = "t1_write";
        fb[0] = 8'h05; fb[1] = 8'hA5; nb = 2; nx = 0;
        run_frame(); check_frame();

        cur = "t2_wrap";
        fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22; nb = 3; nx = 0;
        run_frame(); check_frame();

        cur = "t3_read";
        mem[5] = 8'h3C; mem[6] = 8'h5A;
        fb[0] = 8'h85; fb[1] = 8'h00; fb[2] = 8'h00; nb = 3; nx = 0;
        run_frame(); check_frame();
        chk("rx1_lit", rxb[1], 8'h3C);
        chk("rx2_lit", rxb[2], 8'h5A);

        cur = "t4_partial";
        fb[0] = 8'h10; nb = 1; nx = 3;
        run_frame(); check_frame();

        cur = "t5_cmd_only_read";
        fb[0] = 8'h83; nb = 1; nx = 0;
        run_frame(); check_frame();

        cur = "sclk_cs_high";
        mark();
        for (int i = 0; i < 16; i++) begin
            bus.MOSI = 1'($urandom);
            half();
            bus.SCLK = ~bus.SCLK;
        end
        repeat (10) @(negedge clk);
        chk("we_cnt", we_q.size() - we0, 0);
        chk("re_cnt", re_q.size() - re0, 0);
        chk("done_cnt", done_cnt - done0, 0);
        chk("busy", bus.busy, 0);

        cur = "t6_reset_mid";
        mark();
        bus.CS_L = 1'b0;
        half();
        for (int j = 7; j >= 0; j--) send_bit(j == 1, m);
        send_bit(1'b1, m);
        bus.MOSI = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero();
        rst = 1'b1;
        repeat (1) @(negedge clk);
        bus.SCLK = 1'b1;
        half();
        bus.SCLK = 1'b0;
        for (int j = 0; j < 6; j++) send_bit(1'b1, m);
        chk("busy_after_rel", bus.busy, 0);
        chk("oe_after_rel", bus.MISO_OE, 0);
        for (int j = 7; j >= 0; j--) send_bit(j != 0 && j != 4, m);
        half();
        bus.CS_L = 1'b1;
        repeat (20) @(negedge clk);
        chk("we_cnt", we_q.size() - we0, 0);
        chk("re_cnt", re_q.size() - re0, 0);
        cur = "t6_followup";
        fb[0] = 8'h02; fb[1] = 8'h77; nb = 2; nx = 0;
        run_frame(); check_frame();
        chk("mem2", mem[2], 8'h77);

        for (int k = 0; k < 10; k++) begin
            cur = $sformatf("rand%0d", k);
            nb = $urandom_range(1, 4);
            nx = (k % 3 == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < nb; i++) fb[i] = 8'($urandom);
            run_frame(); check_frame();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
